// File: rtl/wb_inst_feeder.sv
// -----------------------------------------------------------------------------
// wb_inst_feeder
//
// Wishbone slave that feeds instruction words to a core from a small FIFO.
// A read pops one queued instruction and places it in the 32-bit lane chosen
// by adr[3:2]. The other lanes, and every lane on an empty-queue read, carry
// NOP_WORD. A write is reported on the o_wr_* side-band port and has no
// effect on the queue.
//
// Bus handshake: IDLE -> WAIT (ACK_LAT cycles) -> ACK -> IDLE.
// o_wb_ack and o_wb_err are registered and last exactly one cycle. If
// i_wb_cyc drops during WAIT, the transaction is abandoned silently.
//
// Optional feature: define WB_FEEDER_ERR_INJ_EN to add input i_err_req. When
// i_err_req is high at request acceptance, that request ends with o_wb_err
// instead of o_wb_ack and has no other effect.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_push, i_push_inst    enqueue one instruction word
//   o_full, o_empty        queue full / empty
//   o_count                queue occupancy
//   i_wb_*                 Wishbone request (adr, sel, we, dat, cyc, stb)
//   o_wb_dat/ack/err       Wishbone response
//   o_wr_valid/adr/dat/sel one-cycle report of a bus write
//   o_fetch_valid/adr      one-cycle report of a bus read (fetched PC)
//   o_overflow             sticky: push dropped because the queue was full
//   o_underflow            sticky: read served while the queue was empty
// -----------------------------------------------------------------------------
module wb_inst_feeder #(
    parameter int          DATA_W   = 128,
    parameter int          DEPTH    = 8,
    parameter int          ACK_LAT  = 1,
    parameter logic [31:0] NOP_WORD = 32'hF0801003
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
`ifdef WB_FEEDER_ERR_INJ_EN
    input  logic                      i_err_req,
`endif
    input  logic                      i_push,
    input  logic [31:0]               i_push_inst,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count,
    input  logic [31:0]               i_wb_adr,
    input  logic [DATA_W/8-1:0]       i_wb_sel,
    input  logic                      i_wb_we,
    input  logic [DATA_W-1:0]         i_wb_dat,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    output logic [DATA_W-1:0]         o_wb_dat,
    output logic                      o_wb_ack,
    output logic                      o_wb_err,
    output logic                      o_wr_valid,
    output logic [31:0]               o_wr_adr,
    output logic [DATA_W-1:0]         o_wr_dat,
    output logic [DATA_W/8-1:0]       o_wr_sel,
    output logic                      o_fetch_valid,
    output logic [31:0]               o_fetch_adr,
    output logic                      o_overflow,
    output logic                      o_underflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int LANES = DATA_W / 32;
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_wait_cnt, w_wait_cnt_nxt;
    logic                 w_latch, w_enter_ack;

    // Request captured at acceptance
    logic [31:0]          r_adr;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_we;
    logic [DATA_W-1:0]    r_dat;
    logic                 r_err;

    // Instruction queue
    logic [31:0]          r_mem [DEPTH];
    logic [AW-1:0]        r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]        r_count;

    // Registered response / side-band outputs
    logic                 r_ack, r_err_out, r_wr_valid, r_fetch_valid;
    logic [DATA_W-1:0]    r_wb_dat, r_wr_dat;
    logic [31:0]          r_wr_adr, r_fetch_adr;
    logic [SEL_W-1:0]     r_wr_sel;
    logic                 r_overflow, r_underflow;

    logic                 w_err_in;
    logic                 w_from_idle;
    logic                 w_req_we, w_req_err;
    logic [31:0]          w_req_adr;
    logic [SEL_W-1:0]     w_req_sel;
    logic [DATA_W-1:0]    w_req_dat;
    logic                 w_full, w_empty, w_pop, w_push_ok;
    logic [31:0]          w_head;

    logic                 w_ack_nxt, w_err_nxt, w_wr_valid_nxt, w_fetch_valid_nxt;
    logic [DATA_W-1:0]    w_wb_dat_nxt, w_wr_dat_nxt;
    logic [31:0]          w_wr_adr_nxt, w_fetch_adr_nxt;
    logic [SEL_W-1:0]     w_wr_sel_nxt;

`ifdef WB_FEEDER_ERR_INJ_EN
    assign w_err_in = i_err_req;
`else
    assign w_err_in = 1'b0;
`endif

    // ---------------- FSM next state ----------------
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_latch        = 1'b0;
        w_enter_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    w_latch = 1'b1;
                    if (ACK_LAT == 0) begin
                        w_state_nxt = ST_ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_state_nxt    = ST_WAIT;
                        w_wait_cnt_nxt = 3'(ACK_LAT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    w_state_nxt = ST_IDLE;      // master gave up: no ack, no pop
                end else if (r_wait_cnt == 3'd0) begin
                    w_state_nxt = ST_ACK;
                    w_enter_ack = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 3'd1;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;     // never accepts in the ACK cycle
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // With ACK_LAT=0 the edge that accepts the request also enters ACK, so
    // the response is built from the live bus instead of the latched copy.
    assign w_from_idle = (r_state == ST_IDLE);
    assign w_req_we    = w_from_idle ? i_wb_we  : r_we;
    assign w_req_err   = w_from_idle ? w_err_in : r_err;
    assign w_req_adr   = w_from_idle ? i_wb_adr : r_adr;
    assign w_req_sel   = w_from_idle ? i_wb_sel : r_sel;
    assign w_req_dat   = w_from_idle ? i_wb_dat : r_dat;

    // ---------------- Queue control ----------------
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_head    = w_empty ? NOP_WORD : r_mem[r_rd_ptr];
    assign w_pop     = w_enter_ack && !w_req_we && !w_req_err && !w_empty;
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign w_push_ok = i_push && (!w_full || w_pop);

    // ---------------- Response next values ----------------
    always_comb begin
        w_ack_nxt         = w_enter_ack && !w_req_err;
        w_err_nxt         = w_enter_ack &&  w_req_err;
        w_fetch_valid_nxt = w_enter_ack && !w_req_err && !w_req_we;
        w_wr_valid_nxt    = w_enter_ack && !w_req_err &&  w_req_we;
        w_wb_dat_nxt      = '0;
        w_fetch_adr_nxt   = '0;
        w_wr_adr_nxt      = '0;
        w_wr_dat_nxt      = '0;
        w_wr_sel_nxt      = '0;
        if (w_fetch_valid_nxt) begin
            w_fetch_adr_nxt = w_req_adr;
            for (int i = 0; i < LANES; i++) begin
                if (LANES == 1 || i == int'(w_req_adr[3:2]))
                    w_wb_dat_nxt[i*32 +: 32] = w_head;
                else
                    w_wb_dat_nxt[i*32 +: 32] = NOP_WORD;
            end
        end
        if (w_wr_valid_nxt) begin
            w_wr_adr_nxt = w_req_adr;
            w_wr_dat_nxt = w_req_dat;
            w_wr_sel_nxt = w_req_sel;
        end
    end

    // ---------------- State registers ----------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_adr         <= '0;
            r_sel         <= '0;
            r_we          <= 1'b0;
            r_dat         <= '0;
            r_err         <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_ack         <= 1'b0;
            r_err_out     <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_wb_dat      <= '0;
            r_wr_adr      <= '0;
            r_wr_dat      <= '0;
            r_wr_sel      <= '0;
            r_fetch_adr   <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_latch) begin
                r_adr <= i_wb_adr;
                r_sel <= i_wb_sel;
                r_we  <= i_wb_we;
                r_dat <= i_wb_dat;
                r_err <= w_err_in;
            end
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);

            r_ack         <= w_ack_nxt;
            r_err_out     <= w_err_nxt;
            r_wr_valid    <= w_wr_valid_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_wb_dat      <= w_wb_dat_nxt;
            r_wr_adr      <= w_wr_adr_nxt;
            r_wr_dat      <= w_wr_dat_nxt;
            r_wr_sel      <= w_wr_sel_nxt;
            r_fetch_adr   <= w_fetch_adr_nxt;
            if (i_push && w_full && !w_pop)    r_overflow  <= 1'b1;
            if (w_fetch_valid_nxt && w_empty)  r_underflow <= 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, so stale contents are never read.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_inst;
    end

    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_count       = r_count;
    assign o_wb_dat      = r_wb_dat;
    assign o_wb_ack      = r_ack;
    assign o_wb_err      = r_err_out;
    assign o_wr_valid    = r_wr_valid;
    assign o_wr_adr      = r_wr_adr;
    assign o_wr_dat      = r_wr_dat;
    assign o_wr_sel      = r_wr_sel;
    assign o_fetch_valid = r_fetch_valid;
    assign o_fetch_adr   = r_fetch_adr;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_wb_inst_feeder.sv
// -----------------------------------------------------------------------------
// tb_wb_inst_feeder
//
// Self-checking bench for wb_inst_feeder (DATA_W=128, DEPTH=8, ACK_LAT=1).
// The reference model is a queue of words plus two sticky flags; each bus
// transaction pops from it and predicts the lane layout directly from the
// address. Directed scenarios come first, followed by a randomized mix of
// pushes, reads, writes and reads with a push landing on the ACK edge.
// -----------------------------------------------------------------------------
module tb_wb_inst_feeder;

    localparam int          DATA_W  = 128;
    localparam int          DEPTH   = 8;
    localparam int          ACK_LAT = 1;
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP     = 32'hF0801003;

    logic                i_clk = 1'b0;
    logic                i_rst;
`ifdef WB_FEEDER_ERR_INJ_EN
    logic                i_err_req;
`endif
    logic                i_push;
    logic [31:0]         i_push_inst;
    logic                o_full, o_empty;
    logic [CW-1:0]       o_count;
    logic [31:0]         i_wb_adr;
    logic [15:0]         i_wb_sel;
    logic                i_wb_we;
    logic [127:0]        i_wb_dat;
    logic                i_wb_cyc, i_wb_stb;
    logic [127:0]        o_wb_dat;
    logic                o_wb_ack, o_wb_err;
    logic                o_wr_valid;
    logic [31:0]         o_wr_adr;
    logic [127:0]        o_wr_dat;
    logic [15:0]         o_wr_sel;
    logic                o_fetch_valid;
    logic [31:0]         o_fetch_adr;
    logic                o_overflow, o_underflow;

    wb_inst_feeder #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_LAT(ACK_LAT), .NOP_WORD(NOP)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
`ifdef WB_FEEDER_ERR_INJ_EN
        .i_err_req(i_err_req),
`endif
        .i_push(i_push), .i_push_inst(i_push_inst),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
        .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
        .i_wb_dat(i_wb_dat), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_wr_valid(o_wr_valid), .o_wr_adr(o_wr_adr), .o_wr_dat(o_wr_dat),
        .o_wr_sel(o_wr_sel), .o_fetch_valid(o_fetch_valid),
        .o_fetch_adr(o_fetch_adr), .o_overflow(o_overflow),
        .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_q [$];
    logic        model_ovf   = 1'b0;
    logic        model_unf   = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_push(input logic [31:0] w);
        if (model_q.size() < DEPTH) model_q.push_back(w);
        else                        model_ovf = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"},     128'(o_count),     128'(model_q.size()));
        check({tag, ".full"},      128'(o_full),      128'(model_q.size() == DEPTH));
        check({tag, ".empty"},     128'(o_empty),     128'(model_q.size() == 0));
        check({tag, ".overflow"},  128'(o_overflow),  128'(model_ovf));
        check({tag, ".underflow"}, 128'(o_underflow), 128'(model_unf));
    endtask

    task automatic push_word(input logic [31:0] w);
        i_push      = 1'b1;
        i_push_inst = w;
        step();
        i_push      = 1'b0;
        model_push(w);
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endtask

    // One complete bus transaction; optionally a push lands on the ACK edge.
    task automatic wb_txn(input string tag, input logic we, input logic [31:0] adr,
                          input logic [127:0] dat, input logic [15:0] sel,
                          input logic err, input logic push_en, input logic [31:0] push_w);
        int           n;
        int           lane;
        logic [31:0]  word;
        logic [127:0] exp_dat;
        logic         exp_fetch, exp_wr;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_adr = adr;  i_wb_dat = dat;  i_wb_sel = sel;
`ifdef WB_FEEDER_ERR_INJ_EN
        i_err_req = err;
`endif
        i_push      = push_en && (ACK_LAT == 0);
        i_push_inst = push_w;
        step();
        n = 1;
        // Scramble the request lines: the DUT must use its latched copy.
        i_wb_stb = 1'b0; i_wb_we = ~we; i_wb_adr = ~adr; i_wb_dat = ~dat; i_wb_sel = ~sel;
`ifdef WB_FEEDER_ERR_INJ_EN
        i_err_req = ~err;
`endif
        while (!(o_wb_ack || o_wb_err) && n < 16) begin
            i_push = push_en && (n == ACK_LAT);
            step();
            n++;
        end
        i_push = 1'b0;
        check({tag, ".latency"}, 128'(n), 128'(ACK_LAT + 1));

        exp_dat = '0; exp_fetch = 1'b0; exp_wr = 1'b0;
        if (!err && !we) begin
            exp_fetch = 1'b1;
            if (model_q.size() > 0) word = model_q.pop_front();
            else begin word = NOP; model_unf = 1'b1; end
            exp_dat = {4{NOP}};
            lane = int'(adr[3:2]);
            exp_dat[lane*32 +: 32] = word;
        end else if (!err) begin
            exp_wr = 1'b1;
        end
        if (push_en) model_push(push_w);

        check({tag, ".ack"},       128'(o_wb_ack),      128'(!err));
        check({tag, ".err"},       128'(o_wb_err),      128'(err));
        check({tag, ".wb_dat"},    o_wb_dat,            exp_dat);
        check({tag, ".fetch_v"},   128'(o_fetch_valid), 128'(exp_fetch));
        check({tag, ".fetch_adr"}, 128'(o_fetch_adr),   exp_fetch ? 128'(adr) : 128'(0));
        check({tag, ".wr_v"},      128'(o_wr_valid),    128'(exp_wr));
        check({tag, ".wr_adr"},    128'(o_wr_adr),      exp_wr ? 128'(adr) : 128'(0));
        check({tag, ".wr_dat"},    o_wr_dat,            exp_wr ? dat : 128'(0));
        check({tag, ".wr_sel"},    128'(o_wr_sel),      exp_wr ? 128'(sel) : 128'(0));
        check_status({tag, ".at_ack"});

        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        step();
        check({tag, ".ack_end"},   128'(o_wb_ack),      128'(0));
        check({tag, ".err_end"},   128'(o_wb_err),      128'(0));
        check({tag, ".pulse_end"}, 128'({o_fetch_valid, o_wr_valid}), 128'(0));
    endtask

    initial begin
        logic [127:0] rdat;
        i_rst = 1'b1; i_push = 1'b0; i_push_inst = '0;
        i_wb_adr = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_dat = '0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
`ifdef WB_FEEDER_ERR_INJ_EN
        i_err_req = 1'b0;
`endif
        step();
        step();
        // Reset state
        check_status("reset");
        check("reset.outs", 128'({o_wb_ack, o_wb_err, o_wr_valid, o_fetch_valid}), 128'(0));
        check("reset.wb_dat", o_wb_dat, 128'(0));
        check("reset.adrs", 128'({o_fetch_adr, o_wr_adr, o_wr_sel}), 128'(0));
        i_rst = 1'b0;
        step();

        // Single instruction fetched into lane 2
        push_word(32'hE0811002);
        check_status("push1");
        wb_txn("lane2_read", 1'b0, 32'h0000_0008, '0, '0, 1'b0, 1'b0, '0);

        // Empty-queue read
        wb_txn("empty_read", 1'b0, 32'h0000_0000, '0, '0, 1'b0, 1'b0, '0);

        // Write reported on the side-band port
        wb_txn("write", 1'b1, 32'h0000_0100, 128'h55, 16'h000F, 1'b0, 1'b0, '0);

        // Fill past capacity, then drain in order
        for (int i = 0; i <= DEPTH; i++) push_word(32'hA000_0000 + 32'(i));
        check_status("overfill");
        for (int i = 0; i < DEPTH; i++)
            wb_txn("drain", 1'b0, 32'(i) << 2, '0, '0, 1'b0, 1'b0, '0);
        check_status("drained");

        // Push and pop on the same edge: full queue, then empty queue
        for (int i = 0; i < DEPTH; i++) push_word(32'hB000_0000 + 32'(i));
        wb_txn("full_pushpop", 1'b0, 32'h4, '0, '0, 1'b0, 1'b1, 32'hC0DE_0001);
        while (model_q.size() > 0)
            wb_txn("drain2", 1'b0, 32'hC, '0, '0, 1'b0, 1'b0, '0);
        wb_txn("empty_pushpop", 1'b0, 32'h0, '0, '0, 1'b0, 1'b1, 32'hC0DE_0002);

        // Master drops cyc during WAIT: no ack, nothing popped
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h0;
        step();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort.no_ack", 128'({o_wb_ack, o_wb_err, o_fetch_valid}), 128'(0));
        end
        check_status("abort");

        // Reset in WAIT with entries queued and a push on the reset edge
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h0;
        step();
        i_rst = 1'b1; i_push = 1'b1; i_push_inst = 32'h3333_3333;
        step();
        i_rst = 1'b0; i_push = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        model_reset();
        check_status("rst_wait");
        for (int i = 0; i < 3; i++) begin
            check("rst_wait.no_ack", 128'({o_wb_ack, o_wb_err, o_fetch_valid}), 128'(0));
            step();
        end
        wb_txn("after_rst", 1'b0, 32'h0, '0, '0, 1'b0, 1'b0, '0);

`ifdef WB_FEEDER_ERR_INJ_EN
        // Error-injected read leaves the queue untouched
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        model_reset();
        push_word(32'h4444_4444);
        wb_txn("err_read", 1'b0, 32'h0, '0, '0, 1'b1, 1'b0, '0);
        wb_txn("err_write", 1'b1, 32'h20, 128'hFF, 16'hFFFF, 1'b1, 1'b0, '0);
`endif

        // Randomized mix
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    int k;
                    k = int'($urandom_range(1, 4));
                    for (int j = 0; j < k; j++) push_word($urandom);
                    check_status("rnd_push");
                end
                1: wb_txn("rnd_read", 1'b0, $urandom, '0, '0, 1'b0, 1'b0, '0);
                2: begin
                    rdat = {$urandom, $urandom, $urandom, $urandom};
                    wb_txn("rnd_write", 1'b1, $urandom, rdat, 16'($urandom), 1'b0, 1'b0, '0);
                end
                default: wb_txn("rnd_rdpush", 1'b0, $urandom, '0, '0, 1'b0, 1'b1, $urandom);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_inst_feeder.md
WB_INST_FEEDER -- requirements
Module: wb_inst_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning Wishbone data width (32 or 128 only).
REQ-002 SHALL have parameter DEPTH, default 8, meaning instruction queue entries (power of 2, >=2).
REQ-003 SHALL have parameter ACK_LAT, default 1, meaning extra wait cycles before ack (0..7).
REQ-004 SHALL have parameter NOP_WORD, default 32'hF0801003, meaning fill word for idle lanes and empty-queue fetches.
REQ-005 SHALL have ports: i_clk in 1 clock; i_rst in 1 reset (one clock; reset is synchronous and active-high).
REQ-006 SHALL have ports: i_push in 1 queue write; i_push_inst in 32 instruction; o_full out 1; o_empty out 1; o_count out $clog2(DEPTH)+1 occupancy.
REQ-007 SHALL have ports: i_wb_adr in 32; i_wb_sel in DATA_W/8; i_wb_we in 1; i_wb_dat in DATA_W core write data; i_wb_cyc in 1; i_wb_stb in 1.
REQ-008 SHALL have ports: o_wb_dat out DATA_W; o_wb_ack out 1; o_wb_err out 1.
REQ-009 SHALL have ports: o_wr_valid out 1 store pulse; o_wr_adr out 32; o_wr_dat out DATA_W; o_wr_sel out DATA_W/8; o_fetch_valid out 1 fetch pulse; o_fetch_adr out 32 fetched PC; o_overflow out 1 sticky; o_underflow out 1 sticky.

Function
REQ-010 SHALL implement FSM IDLE -> WAIT -> ACK -> IDLE; request accepted in IDLE when i_wb_cyc & i_wb_stb at a rising edge; adr/we/sel/dat latched then.
REQ-011 SHALL stay in WAIT for ACK_LAT cycles (ACK_LAT=0 skips WAIT); o_wb_ack (or o_wb_err) asserted for exactly one cycle in ACK, registered.
REQ-012 SHALL abort to IDLE without ack, pop or pulse if i_wb_cyc drops while in WAIT.
REQ-013 Read (we=0): in ACK, pop one queue entry; o_wb_dat lane i_wb_adr[3:2] = popped instruction, other lanes = NOP_WORD; DATA_W=32 uses single lane; o_fetch_valid pulses with o_fetch_adr = latched adr.
REQ-014 Read with queue empty at ACK: o_wb_dat all lanes NOP_WORD, no pop, o_underflow set; o_fetch_valid still pulses.
REQ-015 Write (we=1): in ACK, o_wr_valid pulses with latched adr/dat/sel; no pop; o_wb_dat = 0.
REQ-016 i_push when not full: enqueue at tail; i_push when full and no pop same cycle: word dropped, o_overflow set.
REQ-017 Simultaneous push and pop when full: both take effect, count unchanged; when empty: pop yields NOP (REQ-014), push stored, count becomes 1.
REQ-018 Pointers wrap modulo DEPTH; o_count, o_full (count==DEPTH), o_empty (count==0) registered-consistent with queue state every cycle.
REQ-019 New request not accepted in ACK cycle; earliest next acceptance is the cycle after ACK.

Reset
REQ-020 i_rst high at rising edge: FSM to IDLE, queue emptied, o_count=0, o_empty=1, o_full=0, all other outputs 0, sticky flags cleared.
REQ-021 Reset during WAIT/ACK SHALL abort the transaction with no ack/err and no pop; reset overrides simultaneous push.

Configuration
REQ-022 Macro WB_FEEDER_ERR_INJ_EN defined: adds input i_err_req 1; if high when request accepted, ACK cycle asserts o_wb_err instead of o_wb_ack, no pop, no o_wr_valid/o_fetch_valid.
REQ-023 WB_FEEDER_ERR_INJ_EN undefined: i_err_req absent, o_wb_err constant 0; all other behaviour identical.

Verification
REQ-024 Push 32'hE0811002, read adr 0x0000_0008, ACK_LAT=1 -> ack 2 cycles after request; lane2 = E0811002, lanes 0,1,3 = F0801003; o_fetch_adr=0x8.
REQ-025 Empty queue read adr 0x0 -> o_wb_dat all F0801003, o_underflow=1, o_count stays 0.
REQ-026 Write adr 0x100, dat lane0 0x55, sel 16'h000F -> o_wr_valid one cycle, o_wr_adr=0x100, o_wr_sel=000F, o_count unchanged.
REQ-027 Push DEPTH+1 words with no reads -> o_full=1, o_overflow=1, last word dropped; then DEPTH reads return first DEPTH words in order, o_empty=1.
REQ-028 Assert i_rst during WAIT with 3 entries queued -> no ack, o_count=0, flags cleared, next read returns NOP_WORD.
REQ-029 With WB_FEEDER_ERR_INJ_EN, i_err_req=1 on read with 1 entry -> o_wb_err pulse, o_wb_ack=0, o_count remains 1.
